// File: rtl/handshake_elastic_fifo_if.sv
// handshake_elastic_fifo_if: producer/consumer ready-valid bundle around the elastic FIFO
interface handshake_elastic_fifo_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic [DATA_WIDTH-1:0]        ins;
    logic                         ins_valid;
    logic                         ins_ready;
    logic [DATA_WIDTH-1:0]        outs;
    logic                         outs_valid;
    logic                         outs_ready;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    modport master (output ins, ins_valid, outs_ready, input ins_ready, outs, outs_valid, occupancy);
    modport slave  (input ins, ins_valid, outs_ready, output ins_ready, outs, outs_valid, occupancy);
endinterface

// File: rtl/handshake_elastic_fifo.sv
// handshake_elastic_fifo: circular-buffer ready/valid FIFO whose handshake outputs decode only registered state
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic clk,
    input logic rst,
    handshake_elastic_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  w_ins_ready;
    logic                  w_outs_valid;
    logic                  w_push;
    logic                  w_pop;
    // ready/valid come from the count register alone, so no input-to-output combinational path exists
    assign w_ins_ready    = r_count != CW'(DEPTH);
    assign w_outs_valid   = r_count != '0;
    assign w_push         = bus.ins_valid & w_ins_ready;
    assign w_pop          = w_outs_valid & bus.outs_ready;
    assign bus.ins_ready  = w_ins_ready;
    assign bus.outs_valid = w_outs_valid;
    assign bus.outs       = w_outs_valid ? r_mem[r_head] : '0;
    assign bus.occupancy  = r_count;
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= bus.ins;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= (r_tail == PW'(DEPTH-1)) ? '0 : r_tail + PW'(1);
            if (w_pop)  r_head <= (r_head == PW'(DEPTH-1)) ? '0 : r_head + PW'(1);
            r_count <= (w_push & ~w_pop) ? r_count + CW'(1) :
                       (w_pop & ~w_push) ? r_count - CW'(1) : r_count;
        end
    end
endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// tb_handshake_elastic_fifo: scenario tasks checked against a queue model of an ideal bounded FIFO
module tb_handshake_elastic_fifo;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic [DW-1:0] q[$];
    handshake_elastic_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) hif();
    handshake_elastic_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(hif));
    always #5 clk = ~clk;
    // {outs_valid, ins_ready, occupancy, outs} as an ideal FIFO holding q would present them
    function automatic logic [DW+CW+1:0] model_view();
        return {q.size() != 0, q.size() != DEPTH, CW'(q.size()), (q.size() != 0) ? q[0] : {DW{1'b0}}};
    endfunction
    function automatic logic [DW+CW+1:0] dut_view();
        return {hif.outs_valid, hif.ins_ready, hif.occupancy, hif.outs};
    endfunction
    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy);
        hif.ins_valid  = iv;
        hif.ins        = d;
        hif.outs_ready = ordy;
    endtask
    task automatic step();
        bit            pu;
        bit            po;
        logic [DW-1:0] d;
        pu = hif.ins_valid && q.size() < DEPTH;
        po = hif.outs_ready && q.size() != 0;
        d  = hif.ins;
        @(posedge clk);
        if (po) void'(q.pop_front());
        if (pu) q.push_back(d);
        #1;
    endtask
    task automatic test_reset();
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        #1;
        vectors++;
        if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL reset: got %h want %h", dut_view(), model_view());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(32'h55 + i), 1'b0);
            step();
        end
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        q.delete();
        #1;
        vectors++;
        if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL reset_mid: got %h want %h", dut_view(), model_view());
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask
    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'(32'hA0 + i), 1'b0);
            #3;
            vectors++;
            if (dut_view() !== model_view()) begin
                miscompares++;
                $display("FAIL fill[%0d]: got %h want %h", i, dut_view(), model_view());
            end
            step();
        end
        drive(1'b0, '0, 1'b0);
        vectors++;
        if (hif.occupancy !== CW'(4) || hif.ins_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full: got occ=%0d rdy=%b want occ=4 rdy=0", hif.occupancy, hif.ins_ready);
        end
    endtask
    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            #3;
            vectors++;
            if (hif.outs !== DW'(32'hA0 + i) || dut_view() !== model_view()) begin
                miscompares++;
                $display("FAIL drain[%0d]: got %h want outs=%h view %h", i, dut_view(), 32'hA0 + i, model_view());
            end
            step();
        end
        #3;
        vectors++;
        if (hif.outs_valid !== 1'b0 || hif.outs !== '0) begin
            miscompares++;
            $display("FAIL drained: got valid=%b outs=%h want 0/0", hif.outs_valid, hif.outs);
        end
    endtask
    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(32'hC0 + i), 1'b0);
            step();
        end
        drive(1'b1, DW'(32'hB0), 1'b1);
        #3;
        vectors++;
        if (hif.ins_ready !== 1'b0 || dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL full_pop_same: got %h want rdy=0 view %h", dut_view(), model_view());
        end
        step();
        drive(1'b0, '0, 1'b0);
        #3;
        vectors++;
        if (hif.occupancy !== CW'(3) || hif.ins_ready !== 1'b1 || dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL full_pop_next: got %h want occ=3 rdy=1 view %h", dut_view(), model_view());
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            step();
        end
        drive(1'b0, '0, 1'b0);
    endtask
    task automatic test_stream();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(32'h100 + i), 1'b1);
            #3;
            vectors++;
            if (dut_view() !== model_view() || (i > 0 && hif.occupancy !== CW'(1))) begin
                miscompares++;
                $display("FAIL stream[%0d]: got %h want %h", i, dut_view(), model_view());
            end
            step();
        end
        drive(1'b0, '0, 1'b1);
        step();
        drive(1'b0, '0, 1'b0);
        #3;
        vectors++;
        if (dut_view() !== model_view()) begin
            miscompares++;
            $display("FAIL stream_end: got %h want %h", dut_view(), model_view());
        end
    endtask
    task automatic test_random();
        int bias;
        for (int c = 0; c < 10000; c++) begin
            bias = ((c / 1000) % 2) ? 8 : 3;
            if (!(hif.ins_valid && !hif.ins_ready)) begin
                hif.ins_valid = ($urandom_range(0, 9) < 6);
                hif.ins       = $urandom;
            end
            hif.outs_ready = ($urandom_range(0, 9) < bias);
            #3;
            vectors++;
            if (dut_view() !== model_view()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h want %h", c, dut_view(), model_view());
            end
            step();
        end
        drive(1'b0, '0, 1'b0);
    endtask
    initial begin
        test_reset();
        test_reset_mid();
        test_fill();
        test_drain();
        test_full_pop();
        test_stream();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
